// File: rtl/midi_uart_rx.sv
// midi_uart_rx: 8N1 UART receiver for the MIDI input path, LSB first.
// Contains a free-running clock-enable divider (strobes at clk/2 .. clk/64).
// One of those strobes is the oversample tick. A 2-flop synchronizer feeds
// a four-state receive FSM. The last good byte is held with a data-ready
// level until the next start bit is detected.
module midi_uart_rx #(
  parameter int TICK_SEL   = 3,  // tick = clk_en[TICK_SEL-1], legal 1..6
  parameter int OVERSAMPLE = 8   // ticks per bit, even and >= 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       uart_in,
  output logic [5:0] clk_en,
  output logic [7:0] uart_data,
  output logic       uart_data_rdy,
  output logic       uart_frame_err
);

  localparam int SCNT_W = $clog2(OVERSAMPLE);
  localparam logic [SCNT_W-1:0] SCNT_HALF = SCNT_W'(OVERSAMPLE / 2);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(OVERSAMPLE - 1);
  localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Divider
  logic [5:0] cnt_q, cnt_d;
  logic [5:0] clk_en_q, clk_en_d;

  // Input synchronizer
  logic rx_meta_q, rx_meta_d;
  logic rx_s_q, rx_s_d;

  // Receiver
  state_t            state_q, state_d;
  logic              armed_q, armed_d;  // line seen high in IDLE since last frame/reset
  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [2:0]        bidx_q, bidx_d;
  logic [7:0]        sh_q, sh_d;
  logic [7:0]        data_q, data_d;
  logic              rdy_q, rdy_d;
  logic              ferr_q, ferr_d;

  logic tick;

  assign tick = clk_en_q[TICK_SEL-1];

  // Divider next-state: strobe i fires the clk after cnt[i:0] is all ones.
  always_comb begin
    cnt_d       = cnt_q + 6'd1;
    clk_en_d[0] = cnt_q[0];
    clk_en_d[1] = &cnt_q[1:0];
    clk_en_d[2] = &cnt_q[2:0];
    clk_en_d[3] = &cnt_q[3:0];
    clk_en_d[4] = &cnt_q[4:0];
    clk_en_d[5] = &cnt_q[5:0];
  end

  // Synchronizer next-state: two stages, decisions use rx_s_q only.
  always_comb begin
    rx_meta_d = uart_in;
    rx_s_d    = rx_meta_q;
  end

  // State register for divider, synchronizer and receiver.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every flop samples the
    // pre-edge value of every other flop; blocking would create order-dependent
    // shortcuts through the synchronizer and divider.
    if (reset) begin
      // NOTE: sync reset clears every flop, including the shift register,
      // so no partial byte can ever survive into uart_data after an abort.
      cnt_q     <= '0;
      clk_en_q  <= '0;
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      armed_q   <= 1'b0;
      scnt_q    <= '0;
      bidx_q    <= '0;
      sh_q      <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_en_q  <= clk_en_d;
      rx_meta_q <= rx_meta_d;
      rx_s_q    <= rx_s_d;
      state_q   <= state_d;
      armed_q   <= armed_d;
      scnt_q    <= scnt_d;
      bidx_q    <= bidx_d;
      sh_q      <= sh_d;
      data_q    <= data_d;
      rdy_q     <= rdy_d;
      ferr_q    <= ferr_d;
    end
  end

  // Receiver next-state and datapath; everything advances only on tick.
  always_comb begin
    // NOTE: every _d defaults to its _q so no path leaves a variable
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    armed_d = armed_q;
    scnt_d  = scnt_q;
    bidx_d  = bidx_q;
    sh_d    = sh_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    ferr_d  = ferr_q;
    if (tick) begin
      unique case (state_q)
        IDLE: begin
          if (!armed_q) begin
            // Break or post-reset: wait for the line to return high.
            if (rx_s_q) armed_d = 1'b1;
          end else if (!rx_s_q) begin
            state_d = START;
            scnt_d  = '0;
            rdy_d   = 1'b0;
          end
        end
        START: begin
          if (scnt_q == SCNT_HALF) begin
            if (rx_s_q) begin
              state_d = IDLE;  // glitch, not a real start bit
            end else begin
              state_d = DATA;
              scnt_d  = '0;
              bidx_d  = '0;
            end
          end else begin
            scnt_d = scnt_q + SCNT_ONE;
          end
        end
        DATA: begin
          if (scnt_q == SCNT_LAST) begin
            sh_d[bidx_q] = rx_s_q;
            scnt_d       = '0;
            if (bidx_q == 3'd7) state_d = STOP;
            else                bidx_d  = bidx_q + 3'd1;
          end else begin
            scnt_d = scnt_q + SCNT_ONE;
          end
        end
        STOP: begin
          if (scnt_q == SCNT_LAST) begin
            if (rx_s_q) begin
              data_d = sh_q;
              rdy_d  = 1'b1;
              ferr_d = 1'b0;
            end else begin
              ferr_d = 1'b1;  // discard frame, keep previous byte
            end
            state_d = IDLE;
            armed_d = 1'b0;
            scnt_d  = '0;
          end else begin
            scnt_d = scnt_q + SCNT_ONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs come straight from flops: glitch-free strobes and data.
  always_comb begin
    clk_en         = clk_en_q;
    uart_data      = data_q;
    uart_data_rdy  = rdy_q;
    uart_frame_err = ferr_q;
  end

endmodule

// File: tb/tb_midi_uart_rx.sv
// tb_midi_uart_rx: scoreboard bench for midi_uart_rx at default parameters
// (tick = clk_en[2], 8 ticks per bit). Good frames push their byte when the
// start bit is driven; a monitor pops on each rising edge of uart_data_rdy.
module tb_midi_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       uart_in = 1'b1;
  logic [5:0] clk_en;
  logic [7:0] uart_data;
  logic       uart_data_rdy;
  logic       uart_frame_err;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb_q[$];

  midi_uart_rx dut (
    .clk           (clk),
    .reset         (reset),
    .uart_in       (uart_in),
    .clk_en        (clk_en),
    .uart_data     (uart_data),
    .uart_data_rdy (uart_data_rdy),
    .uart_frame_err(uart_frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to the next negedge inside a tick strobe (bounded).
  task automatic wait_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!clk_en[2] && n < 64);
    if (!clk_en[2]) check("tick_timeout", 32'(clk_en[2]), 32'd1);
  endtask

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) wait_tick();
  endtask

  // Drive one 8N1 frame starting now (caller is aligned on a tick).
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    uart_in = 1'b0;
    if (stop_ok) sb_q.push_back(b);
    wait_ticks(4);
    check("rdy_clr_at_start", 32'(uart_data_rdy), 32'd0);
    wait_ticks(4);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      wait_ticks(8);
    end
    uart_in = stop_ok;
    wait_ticks(8);
    check("rdy_end_stop", 32'(uart_data_rdy), 32'(stop_ok));
    check("ferr_end_stop", 32'(uart_frame_err), 32'(!stop_ok));
  endtask

  // Scoreboard monitor: each rising rdy must match the oldest queued byte.
  initial begin
    logic       prev = 1'b0;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (uart_data_rdy && !prev) begin
        check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          exp_b = sb_q.pop_front();
          check("rx_byte", 32'(uart_data), 32'(exp_b));
        end
      end
      prev = uart_data_rdy;
    end
  end

  initial begin
    int last [6];
    int seen [6];

    // Reset values
    @(negedge clk);
    check("rst_clk_en", 32'(clk_en), 32'd0);
    check("rst_data", 32'(uart_data), 32'h00);
    check("rst_rdy", 32'(uart_data_rdy), 32'd0);
    check("rst_ferr", 32'(uart_frame_err), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_clk_en", 32'(clk_en), 32'd0);

    // Divider: spacing and count of every strobe over 128 clks
    for (int i = 0; i < 6; i++) begin
      last[i] = -1;
      seen[i] = 0;
    end
    for (int n = 0; n < 128; n++) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) begin
        if (clk_en[i]) begin
          if (last[i] >= 0) check($sformatf("en%0d_period", i), 32'(n - last[i]), 32'(1 << (i + 1)));
          last[i] = n;
          seen[i]++;
        end
      end
    end
    check("en0_count", 32'(seen[0]), 32'd64);
    check("en2_count", 32'(seen[2]), 32'd16);
    check("en5_count", 32'(seen[5]), 32'd2);

    // Single byte, then back-to-back 0x55 / 0xAA
    wait_ticks(2);
    send_byte(8'hDE, 1'b1);
    check("data_de", 32'(uart_data), 32'hDE);
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    check("data_aa", 32'(uart_data), 32'hAA);

    // Glitch: 2 ticks low is rejected, rdy cleared, data kept
    uart_in = 1'b0;
    wait_ticks(2);
    uart_in = 1'b1;
    wait_ticks(12);
    check("glitch_rdy", 32'(uart_data_rdy), 32'd0);
    check("glitch_data", 32'(uart_data), 32'hAA);
    send_byte(8'h3C, 1'b1);

    // Framing error keeps the old byte
    send_byte(8'h81, 1'b0);
    check("ferr_data_kept", 32'(uart_data), 32'h3C);
    uart_in = 1'b1;
    wait_ticks(4);

    // Mid-frame reset aborts the frame
    uart_in = 1'b0;
    wait_ticks(20);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_data", 32'(uart_data), 32'h00);
    check("midrst_rdy", 32'(uart_data_rdy), 32'd0);
    check("midrst_ferr", 32'(uart_frame_err), 32'd0);

    // Line still low after reset: no start may be accepted
    wait_ticks(90);
    check("break_ferr", 32'(uart_frame_err), 32'd0);
    check("break_rdy", 32'(uart_data_rdy), 32'd0);
    uart_in = 1'b1;
    wait_ticks(3);
    send_byte(8'h96, 1'b1);
    check("data_96", 32'(uart_data), 32'h96);
    wait_ticks(2);
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
